imm_encoder: RTL and testbench
==============================

IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 The block SHALL have these ports (clock and reset first):
 clk  in  1  single clock, all state on rising edge
 rst  in  1  synchronous, active-high reset
 in_valid  in  1  request present
 in_ready  out  1  block accepts request this cycle
 in_fmt  in  3  0=R,1=I,2=S,3=B,4=U,5=J; 6-7 illegal
 in_opcode  in  7  opcode, placed at inst[6:0]
 in_rd  in  5  destination register
 in_rs1  in  5  source register 1
 in_rs2  in  5  source register 2
 in_funct3  in  3  funct3
 in_funct7  in  7  funct7, R format only
 in_imm  in  32  full-width signed immediate value, not pre-shifted
 out_valid  out  1  encoded instruction present
 out_ready  in  1  consumer accepts
 out_inst  out  32  encoded RV32I instruction
 out_err  out  1  immediate out of range, misaligned or illegal fmt
 err_count  out  16  saturating count of errored instructions delivered

Function
REQ-002 Two-stage pipeline: S1 registers the inputs and the range check; S2 registers out_inst/out_err. Minimum latency is 2 cycles from the accepting edge to out_valid.
REQ-003 Each stage SHALL load when it is empty or when its downstream consumer takes its contents this cycle. in_ready = !S1.valid || S2 loads; no combinational path from in_valid to in_ready.
REQ-004 A transfer occurs when valid && ready. out_inst and out_err SHALL hold stable while out_valid && !out_ready.
REQ-005 Full-throughput streaming with out_ready=1 SHALL accept one request per cycle. No request is dropped or duplicated under any out_ready pattern.
REQ-006 Encodings (standard RV32I field placement):
 - R: funct7|rs2|rs1|funct3|rd|opcode.
 - I: imm[11:0]|rs1|funct3|rd|opcode.
 - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
 - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
 - U: imm[31:12]|rd|opcode.
 - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
REQ-007 Error rules:
 - I/S: err unless imm[31:11] are all equal.
 - B: err unless imm[31:12] are all equal and imm[0]=0.
 - J: err unless imm[31:20] are all equal and imm[0]=0.
 - U: err unless imm[11:0]=0.
 - R: in_imm is ignored, never an error.
 - fmt 6-7: err=1 and out_inst=0.
REQ-008 An errored instruction SHALL still be delivered, with fields filled from the truncated immediate bits.
REQ-009 err_count SHALL increment by 1 on each output transfer with out_err=1, and saturate at 0xFFFF.

Reset
REQ-010 When rst=1 at a clock edge: both stage valids=0, out_valid=0, out_inst=0, out_err=0, err_count=0. in_ready=1 in the first cycle after reset.
REQ-011 Reset mid-operation SHALL discard all in-flight requests. No transfer completes in the reset cycle.

Structure
REQ-012 A shared package SHALL hold the fmt encodings (FMT_R..FMT_J) and the RV32I opcode constants, for reuse alongside the decoder side of the datapath.
REQ-013 The block SHALL contain one combinational sub-module, imm_pack (fmt, fields, imm -> inst, err), instantiated in S1.

Verification
REQ-014 I, fmt=1, opcode=0x13, rd=1, rs1=0, f3=0, imm=-1 -> out_inst=0xFFF00093, err=0, two cycles after acceptance.
REQ-015 B, opcode=0x63, rs1=1, rs2=2, f3=0, imm=-4 -> 0xFE208EE3. J, opcode=0x6F, rd=1, imm=8 -> 0x008000EF. U, opcode=0x37, rd=5, imm=0x12345000 -> 0x123452B7.
REQ-016 I with imm=2048 -> err=1, inst[31:20]=0x800, err_count=1. B with imm=6 (legal range, not misaligned) -> err=0. J with imm=3 -> err=1.
REQ-017 Stream 8 requests with out_ready toggling 1,0,0,1,... -> all 8 outputs in order, stable while stalled, in_ready low only when both stages are full.
REQ-018 Assert rst with 2 in flight -> out_valid=0 next cycle, err_count=0, the next request encodes correctly. err_count preset near 0xFFFF -> holds at 0xFFFF.

Source files
------------

// File: rtl/imm_encoder_pkg.sv
// Shared RV32I encoding constants and record types for the instruction
// encoder/decoder datapath.
package imm_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } enc_res_t;

  // True when imm[31:lsb] is a pure sign extension (all zeros or all ones).
  function automatic logic sext_fits(input logic [31:0] imm, input int unsigned lsb);
    logic [31:0] t;
    t = $signed(imm) >>> lsb;
    return (t == '0) || (t == '1);
  endfunction

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational RV32I field packer: places fields and immediate bits for the
// selected format and flags out-of-range, misaligned or illegal formats.
module imm_pack
  import imm_encoder_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        err
);

  always_comb begin
    inst = '0;
    err  = 1'b0;
    case (fmt)
      FMT_R: begin
        inst = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      FMT_I: begin
        inst = {imm[11:0], rs1, funct3, rd, opcode};
        err  = !sext_fits(imm, 11);
      end
      FMT_S: begin
        inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err  = !sext_fits(imm, 11);
      end
      FMT_B: begin
        inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err  = !sext_fits(imm, 12) || imm[0];
      end
      FMT_U: begin
        inst = {imm[31:12], rd, opcode};
        err  = |imm[11:0];
      end
      FMT_J: begin
        inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err  = !sext_fits(imm, 20) || imm[0];
      end
      default: begin
        inst = '0;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready pipeline encoding RV32I instructions from fields and
// a full-width immediate, with a saturating count of errored outputs.
module imm_encoder
  import imm_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [15:0] err_count
);

  logic     s1_valid;
  logic     s2_valid;
  logic     s1_load;
  logic     s2_load;
  enc_res_t s1_res;
  enc_res_t pack_res;

  imm_pack u_pack (
    .fmt    (in_fmt),
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .inst   (pack_res.inst),
    .err    (pack_res.err)
  );

  // Each stage refills when empty or when its contents leave this cycle;
  // in_ready depends only on registered state and out_ready.
  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_res    <= '0;
      s2_valid  <= 1'b0;
      out_inst  <= '0;
      out_err   <= 1'b0;
      err_count <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= in_valid;
        if (in_valid) s1_res <= pack_res;
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_inst <= s1_res.inst;
          out_err  <= s1_res.err;
        end
      end
      if (s2_valid && out_ready && out_err && (err_count != '1))
        err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed vector table, reset and
// backpressure sequences, randomized streaming against a reference model.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  imm_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .err_count (err_count)
  );

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  int unsigned tests = 0;
  int unsigned fails = 0;
  exp_t        q[$];
  int unsigned exp_cnt = 0;
  int unsigned delivered = 0;
  logic        held_v = 1'b0;
  logic [31:0] held_inst;
  logic        held_err;
  vec_t        vt[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
    return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
  endfunction

  // Reference: fields shifted into place arithmetically, legality from numeric ranges.
  function automatic exp_t ref_encode(input logic [2:0] fmt, input logic [6:0] op,
                                      input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [2:0] f3,
                                      input logic [6:0] f7, input logic [31:0] imm);
    exp_t        r;
    longint      s;
    logic [31:0] base;
    s = longint'($signed(imm));
    base = 32'(op) | (32'(f3) << 12) | (32'(rs1) << 15);
    r.inst = '0;
    r.err = 1'b0;
    case (fmt)
      3'd0: r.inst = base | (32'(rd) << 7) | (32'(rs2) << 20) | (32'(f7) << 25);
      3'd1: begin
        r.inst = base | (32'(rd) << 7) | (fld(imm, 11, 0) << 20);
        r.err = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        r.inst = base | (fld(imm, 4, 0) << 7) | (32'(rs2) << 20) | (fld(imm, 11, 5) << 25);
        r.err = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        r.inst = base | (fld(imm, 11, 11) << 7) | (fld(imm, 4, 1) << 8) | (32'(rs2) << 20)
               | (fld(imm, 10, 5) << 25) | (fld(imm, 12, 12) << 31);
        r.err = (s < -4096) || (s > 4095) || ((s % 2) != 0);
      end
      3'd4: begin
        r.inst = 32'(op) | (32'(rd) << 7) | (fld(imm, 31, 12) << 12);
        r.err = (imm % 32'd4096) != 32'd0;
      end
      3'd5: begin
        r.inst = 32'(op) | (32'(rd) << 7) | (fld(imm, 19, 12) << 12) | (fld(imm, 11, 11) << 20)
               | (fld(imm, 10, 1) << 21) | (fld(imm, 20, 20) << 31);
        r.err = (s < -1048576) || (s > 1048575) || ((s % 2) != 0);
      end
      default: begin
        r.inst = '0;
        r.err = 1'b1;
      end
    endcase
    return r;
  endfunction

  task automatic apply_vec(input vec_t v);
    in_fmt = v.fmt; in_opcode = v.op; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
  endtask

  task automatic rand_req();
    in_fmt = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
    in_opcode = 7'($urandom); in_rd = 5'($urandom); in_rs1 = 5'($urandom);
    in_rs2 = 5'($urandom); in_funct3 = 3'($urandom); in_funct7 = 7'($urandom);
    case ($urandom_range(0, 3))
      0: in_imm = 32'($urandom);
      1: in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      2: in_imm = 32'($urandom) & 32'hFFFFF000;
      default: in_imm = 32'($urandom_range(0, 4194303)) - 32'd2097152;
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete(); exp_cnt = 0; held_v = 1'b0; delivered = 0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  // One scoreboarded clock cycle: sample at negedge, then advance past posedge.
  task automatic sb_cycle(output bit acc);
    exp_t e;
    @(negedge clk);
    check("err_count", 32'(err_count), exp_cnt);
    check("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
    if (held_v) begin
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_inst", out_inst, held_inst);
      check("stall_err", 32'(out_err), 32'(held_err));
    end
    held_v = out_valid && !out_ready;
    held_inst = out_inst;
    held_err = out_err;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_output: got 0x%08h, expected no output", out_inst);
      end else begin
        e = q.pop_front();
        check("inst", out_inst, e.inst);
        check("err", 32'(out_err), 32'(e.err));
        delivered++;
        if (e.err && exp_cnt < 65535) exp_cnt++;
      end
    end
    acc = in_valid && in_ready;
    if (acc)
      q.push_back(ref_encode(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    bit acc;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() != 0; i++) sb_cycle(acc);
    check(name, 32'(q.size()), 32'd0);
  endtask

  initial begin
    bit acc;
    int unsigned sent;
    int unsigned pat[4] = '{1, 0, 0, 1};

    //          fmt   op     rd    rs1   rs2   f3    f7     imm           inst          err
    vt[0]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 32'hFFF00093, 1'b0};
    vt[1]  = '{3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0};
    vt[2]  = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000008, 32'h008000EF, 1'b0};
    vt[3]  = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 32'h123452B7, 1'b0};
    vt[4]  = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800, 32'h80000093, 1'b1};
    vt[5]  = '{3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00000006, 32'h00208363, 1'b0};
    vt[6]  = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000003, 32'h002000EF, 1'b1};
    vt[7]  = '{3'd0, 7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'hDEADBEEF, 32'h405201B3, 1'b0};
    vt[8]  = '{3'd2, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'h00, 32'hFFFFFFF8, 32'hFE512C23, 1'b0};
    vt[9]  = '{3'd6, 7'h13, 5'd1, 5'd2, 5'd3, 3'd1, 7'h7F, 32'h00000005, 32'h00000000, 1'b1};
    vt[10] = '{3'd7, 7'h33, 5'd4, 5'd5, 5'd6, 3'd7, 7'h01, 32'h00000000, 32'h00000000, 1'b1};
    vt[11] = '{3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345001, 32'h123452B7, 1'b1};
    vt[12] = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF800, 32'h80000093, 1'b0};
    vt[13] = '{3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h00001000, 32'h80208063, 1'b1};
    vt[14] = '{3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFF00000, 32'h800000EF, 1'b0};

    in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    do_reset();

    // Directed table: one request at a time, latency and value checked.
    for (int i = 0; i < 15; i++) begin
      apply_vec(vt[i]);
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check($sformatf("v%0d_lat1_valid", i), 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check($sformatf("v%0d_lat2_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("v%0d_inst", i), out_inst, vt[i].inst);
      check($sformatf("v%0d_err", i), 32'(out_err), 32'(vt[i].err));
      @(posedge clk); #1;
      if (vt[i].err) exp_cnt++;
      check($sformatf("v%0d_err_count", i), 32'(err_count), exp_cnt);
      check($sformatf("v%0d_drained", i), 32'(out_valid), 32'd0);
    end

    // Reset with two errored requests in flight, then a clean request.
    apply_vec(vt[4]);
    in_valid = 1'b1; out_ready = 1'b0;
    sb_cycle(acc);
    sb_cycle(acc);
    check("midrst_inflight", 32'(q.size()), 32'd2);
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    q.delete(); exp_cnt = 0; held_v = 1'b0; delivered = 0;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_err_count", 32'(err_count), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    apply_vec(vt[1]);
    in_valid = 1'b1;
    sb_cycle(acc);
    drain("midrst_drain");
    check("midrst_delivered", delivered, 32'd1);

    // Eight requests under out_ready pattern 1,0,0,1,...
    do_reset();
    sent = 0;
    rand_req();
    for (int c = 0; c < 80 && (sent < 8 || q.size() != 0); c++) begin
      out_ready = pat[c % 4][0];
      in_valid = (sent < 8);
      sb_cycle(acc);
      if (acc) begin
        sent++;
        rand_req();
      end
    end
    in_valid = 1'b0;
    check("toggle_sent", sent, 32'd8);
    check("toggle_delivered", delivered, 32'd8);

    // Randomized traffic with random backpressure.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (!in_valid || acc) rand_req();
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      sb_cycle(acc);
    end
    drain("random_drain");

    // Error counter saturation.
    do_reset();
    apply_vec(vt[4]);
    out_ready = 1'b1;
    sent = 0;
    for (int c = 0; c < 65600 && sent < 65540; c++) begin
      in_valid = 1'b1;
      sb_cycle(acc);
      if (acc) sent++;
    end
    drain("sat_drain");
    check("sat_sent", sent, 32'd65540);
    check("sat_err_count", 32'(err_count), 32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
